ift_taint_monitor: RTL and testbench

Downstream observer for IFT-instrumented cells such as the tainted 2:1 mux: samples a cell's `out`/`out_t` pair every valid cycle, tracks taint state, accumulates a sticky taint-label union and tainted-cycle count, and logs every taint-vector change into a small event FIFO that a bench or on-chip logger drains over a valid/ready handshake. It gives IFT regression tests a cycle-accurate record of when and how taint reached a cell output, instead of relying only on VCD inspection.

---
 rtl/ift_taint_monitor.sv | 212 +++++++++++++++++++++
 tb/tb_ift_taint_monitor.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ift_taint_monitor.sv
// Taint observer for IFT-instrumented cells: tracks taint state, sticky label union and
// tainted-cycle count, and logs taint changes to an event FIFO. Option macro: IFT_MON_DATA_EN.
module ift_taint_monitor #(
    parameter int TAINT_W = 32,
    parameter int CNT_W   = 16,
    parameter int DEPTH   = 8,
`ifdef IFT_MON_DATA_EN
    localparam int EV_W   = CNT_W + TAINT_W + 1
`else
    localparam int EV_W   = CNT_W + TAINT_W
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    input  logic               in_data,
    input  logic [TAINT_W-1:0] in_t,
    output logic               ev_valid,
    input  logic               ev_ready,
    output logic [EV_W-1:0]    ev_data,
    output logic [TAINT_W-1:0] sticky_t,
    output logic [CNT_W-1:0]   taint_cycles,
    output logic [CNT_W-1:0]   first_cycle,
    output logic [1:0]         state,
    output logic               overflow
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TAINTED = 2'd1,
        CLEANED = 2'd2
    } state_e;

    state_e             state_r;
    state_e             state_nxt_s;
    logic [CNT_W-1:0]   stamp_r;
    logic [CNT_W-1:0]   stamp_nxt_s;
    logic [TAINT_W-1:0] prev_t_r;
    logic [TAINT_W-1:0] sticky_r;
    logic [CNT_W-1:0]   taint_cycles_r;
    logic [CNT_W-1:0]   taint_cycles_nxt_s;
    logic [CNT_W-1:0]   first_cycle_r;
    logic               overflow_r;
    logic               taint_nz_s;
    logic               event_s;
    logic [EV_W-1:0]    entry_s;

    logic [EV_W-1:0]    mem_r [DEPTH];
    logic [AW:0]        wr_ptr_r;
    logic [AW:0]        rd_ptr_r;
    logic [AW:0]        wr_nxt_s;
    logic [AW:0]        rd_nxt_s;
    logic               ev_valid_r;
    logic               ev_valid_nxt_s;
    logic [EV_W-1:0]    ev_data_r;
    logic [EV_W-1:0]    ev_data_nxt_s;
    logic               full_s;
    logic               push_s;
    logic               pop_s;
    logic               drop_s;

    assign taint_nz_s = |in_t;

`ifdef IFT_MON_DATA_EN
    logic prev_data_r;

    // A data flip on an already-tainted output is also worth logging.
    assign event_s = in_valid && !clear &&
                     ((in_t != prev_t_r) || (taint_nz_s && (in_data != prev_data_r)));
    assign entry_s = {stamp_r, in_t, in_data};

    // Last sampled cell value, compared against the next sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_data_r <= 1'b0;
        end else if (clear) begin
            prev_data_r <= 1'b0;
        end else if (in_valid) begin
            prev_data_r <= in_data;
        end
    end
`else
    logic unused_data_s;

    assign unused_data_s = in_data;
    assign event_s       = in_valid && !clear && (in_t != prev_t_r);
    assign entry_s       = {stamp_r, in_t};
`endif

    // Next-state for the taint FSM; it only moves on valid samples.
    always_comb begin
        state_nxt_s = state_r;
        if (in_valid) begin
            case (state_r)
                IDLE:    if (taint_nz_s) state_nxt_s = TAINTED; else state_nxt_s = IDLE;
                TAINTED: if (taint_nz_s) state_nxt_s = TAINTED; else state_nxt_s = CLEANED;
                CLEANED: if (taint_nz_s) state_nxt_s = TAINTED; else state_nxt_s = CLEANED;
                default: state_nxt_s = IDLE;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Saturating increments for the sample stamp and tainted-cycle counter.
    always_comb begin
        stamp_nxt_s        = stamp_r;
        taint_cycles_nxt_s = taint_cycles_r;
        if (stamp_r != {CNT_W{1'b1}}) begin
            stamp_nxt_s = stamp_r + CNT_W'(1);
        end else begin
            stamp_nxt_s = stamp_r;
        end
        if (taint_nz_s && (taint_cycles_r != {CNT_W{1'b1}})) begin
            taint_cycles_nxt_s = taint_cycles_r + CNT_W'(1);
        end else begin
            taint_cycles_nxt_s = taint_cycles_r;
        end
    end

    // Status registers; clear wins over a same-cycle sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= IDLE;
            stamp_r        <= {CNT_W{1'b0}};
            prev_t_r       <= {TAINT_W{1'b0}};
            sticky_r       <= {TAINT_W{1'b0}};
            taint_cycles_r <= {CNT_W{1'b0}};
            first_cycle_r  <= {CNT_W{1'b0}};
            overflow_r     <= 1'b0;
        end else if (clear) begin
            state_r        <= IDLE;
            stamp_r        <= {CNT_W{1'b0}};
            prev_t_r       <= {TAINT_W{1'b0}};
            sticky_r       <= {TAINT_W{1'b0}};
            taint_cycles_r <= {CNT_W{1'b0}};
            first_cycle_r  <= {CNT_W{1'b0}};
            overflow_r     <= 1'b0;
        end else begin
            if (in_valid) begin
                state_r        <= state_nxt_s;
                stamp_r        <= stamp_nxt_s;
                prev_t_r       <= in_t;
                sticky_r       <= sticky_r | in_t;
                taint_cycles_r <= taint_cycles_nxt_s;
                if ((state_r == IDLE) && taint_nz_s) begin
                    first_cycle_r <= stamp_r;
                end
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign full_s = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign pop_s  = ev_valid_r && ev_ready;
    assign push_s = event_s && (!full_s || pop_s);
    assign drop_s = event_s && !push_s;

    // Next FIFO pointers and the registered head; a push into the slot that
    // becomes the head bypasses storage so ev_valid rises one edge after the push.
    always_comb begin
        wr_nxt_s       = wr_ptr_r + {{AW{1'b0}}, push_s};
        rd_nxt_s       = rd_ptr_r + {{AW{1'b0}}, pop_s};
        ev_valid_nxt_s = (wr_nxt_s != rd_nxt_s);
        if (push_s && (wr_ptr_r[AW-1:0] == rd_nxt_s[AW-1:0])) begin
            ev_data_nxt_s = entry_s;
        end else begin
            ev_data_nxt_s = mem_r[rd_nxt_s[AW-1:0]];
        end
    end

    // FIFO pointers and head register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= {(AW+1){1'b0}};
            rd_ptr_r   <= {(AW+1){1'b0}};
            ev_valid_r <= 1'b0;
            ev_data_r  <= {EV_W{1'b0}};
        end else if (clear) begin
            wr_ptr_r   <= {(AW+1){1'b0}};
            rd_ptr_r   <= {(AW+1){1'b0}};
            ev_valid_r <= 1'b0;
            ev_data_r  <= {EV_W{1'b0}};
        end else begin
            wr_ptr_r   <= wr_nxt_s;
            rd_ptr_r   <= rd_nxt_s;
            ev_valid_r <= ev_valid_nxt_s;
            ev_data_r  <= ev_data_nxt_s;
        end
    end

    // Event storage; contents are only visible through the head register.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= entry_s;
        end
    end

    assign ev_valid     = ev_valid_r;
    assign ev_data      = ev_data_r;
    assign sticky_t     = sticky_r;
    assign taint_cycles = taint_cycles_r;
    assign first_cycle  = first_cycle_r;
    assign state        = state_r;
    assign overflow     = overflow_r;

endmodule

// File: tb/tb_ift_taint_monitor.sv
// Directed self-checking bench for ift_taint_monitor: a vector table for the
// sample/status path plus hand-written FIFO overflow, full-throughput, clear and reset sequences.
module tb_ift_taint_monitor;

    localparam int TW = 32;
    localparam int CW = 16;
`ifdef IFT_MON_DATA_EN
    localparam int EW = CW + TW + 1;
`else
    localparam int EW = CW + TW;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_data = 1'b0;
    logic [TW-1:0] in_t = '0;
    logic          ev_ready = 1'b0;
    logic          ev_valid;
    logic [EW-1:0] ev_data;
    logic [TW-1:0] sticky_t;
    logic [CW-1:0] taint_cycles;
    logic [CW-1:0] first_cycle;
    logic [1:0]    state;
    logic          overflow;

    int errors = 0;
    int checks = 0;

    ift_taint_monitor #(.TAINT_W(TW), .CNT_W(CW), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_t(in_t), .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_data(ev_data),
        .sticky_t(sticky_t), .taint_cycles(taint_cycles), .first_cycle(first_cycle),
        .state(state), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          clr;
        logic          vld;
        logic [TW-1:0] t;
        logic          rdy;
        logic          e_v;
        logic [CW-1:0] e_stamp;
        logic [TW-1:0] e_tag;
        logic [1:0]    e_state;
        logic [TW-1:0] e_sticky;
        logic [CW-1:0] e_tc;
        logic [CW-1:0] e_first;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    function automatic vec_t mkv(input logic clr, input logic vld, input logic [TW-1:0] t,
                                 input logic rdy, input logic e_v, input logic [CW-1:0] e_stamp,
                                 input logic [TW-1:0] e_tag, input logic [1:0] e_state,
                                 input logic [TW-1:0] e_sticky, input logic [CW-1:0] e_tc,
                                 input logic [CW-1:0] e_first);
        vec_t v;
        v.clr = clr; v.vld = vld; v.t = t; v.rdy = rdy; v.e_v = e_v;
        v.e_stamp = e_stamp; v.e_tag = e_tag; v.e_state = e_state;
        v.e_sticky = e_sticky; v.e_tc = e_tc; v.e_first = e_first;
        return v;
    endfunction

    function automatic logic [EW-1:0] mk_ev(input logic [CW-1:0] s, input logic [TW-1:0] t,
                                            input logic d);
`ifdef IFT_MON_DATA_EN
        return {s, t, d};
`else
        logic unused_d;
        unused_d = d;
        return {s, t};
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, then settle just after the rising edge.
    task automatic step(input logic clr, input logic vld, input logic dat,
                        input logic [TW-1:0] t, input logic rdy);
        @(negedge clk);
        clear = clr; in_valid = vld; in_data = dat; in_t = t; ev_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    // Check n consecutive heads with alternating 0x1/0x0 taint, popping each one.
    task automatic drain(input int first_stamp, input int n);
        for (int k = 0; k < n; k++) begin
            chk("drain_valid", 64'(ev_valid), 64'd1);
            chk("drain_data", 64'(ev_data),
                64'(mk_ev(CW'(first_stamp + k), ((first_stamp + k) % 2 == 0) ? 32'h1 : 32'h0, 1'b0)));
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        end
        chk("drain_empty", 64'(ev_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset-state checks.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ev_valid", 64'(ev_valid), 64'd0);
        chk("rst_ev_data", 64'(ev_data), 64'd0);
        chk("rst_sticky", 64'(sticky_t), 64'd0);
        chk("rst_tc", 64'(taint_cycles), 64'd0);
        chk("rst_first", 64'(first_cycle), 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        //               clr   vld   t       rdy   e_v   stamp  tag    st    sticky  tc     first
        for (int i = 0; i < 5; i++)
            vecs[i] = mkv(1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 16'd0, 32'h0, 2'd0, 32'h0, 16'd0, 16'd0);
        vecs[5]  = mkv(1'b1, 1'b0, 32'h0,  1'b1, 1'b0, 16'd0, 32'h0, 2'd0, 32'h0, 16'd0, 16'd0);
        vecs[6]  = mkv(1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 16'd0, 32'h0, 2'd0, 32'h0, 16'd0, 16'd0);
        vecs[7]  = mkv(1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 16'd0, 32'h0, 2'd0, 32'h0, 16'd0, 16'd0);
        vecs[8]  = mkv(1'b0, 1'b1, 32'h1,  1'b1, 1'b1, 16'd2, 32'h1, 2'd1, 32'h1, 16'd1, 16'd2);
        vecs[9]  = mkv(1'b0, 1'b1, 32'h1,  1'b1, 1'b0, 16'd0, 32'h0, 2'd1, 32'h1, 16'd2, 16'd2);
        vecs[10] = mkv(1'b0, 1'b1, 32'h4,  1'b1, 1'b1, 16'd4, 32'h4, 2'd1, 32'h5, 16'd3, 16'd2);
        vecs[11] = mkv(1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 16'd5, 32'h0, 2'd2, 32'h5, 16'd3, 16'd2);
        vecs[12] = mkv(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 16'd0, 32'h0, 2'd2, 32'h5, 16'd3, 16'd2);
        vecs[13] = mkv(1'b0, 1'b1, 32'h2,  1'b1, 1'b1, 16'd6, 32'h2, 2'd1, 32'h7, 16'd4, 16'd2);
        vecs[14] = mkv(1'b1, 1'b1, 32'hFF, 1'b1, 1'b0, 16'd0, 32'h0, 2'd0, 32'h0, 16'd0, 16'd0);
        vecs[15] = mkv(1'b0, 1'b1, 32'h3,  1'b1, 1'b1, 16'd0, 32'h3, 2'd1, 32'h3, 16'd1, 16'd0);
        vecs[16] = mkv(1'b0, 1'b0, 32'h0,  1'b1, 1'b0, 16'd0, 32'h0, 2'd1, 32'h3, 16'd1, 16'd0);

        for (int i = 0; i < NV; i++) begin
            step(vecs[i].clr, vecs[i].vld, 1'b0, vecs[i].t, vecs[i].rdy);
            chk($sformatf("v%0d_ev_valid", i), 64'(ev_valid), 64'(vecs[i].e_v));
            if (vecs[i].e_v)
                chk($sformatf("v%0d_ev_data", i), 64'(ev_data),
                    64'(mk_ev(vecs[i].e_stamp, vecs[i].e_tag, 1'b0)));
            chk($sformatf("v%0d_state", i), 64'(state), 64'(vecs[i].e_state));
            chk($sformatf("v%0d_sticky", i), 64'(sticky_t), 64'(vecs[i].e_sticky));
            chk($sformatf("v%0d_tc", i), 64'(taint_cycles), 64'(vecs[i].e_tc));
            chk($sformatf("v%0d_first", i), 64'(first_cycle), 64'(vecs[i].e_first));
            chk($sformatf("v%0d_overflow", i), 64'(overflow), 64'd0);
        end

        // Overflow: ten events into an 8-deep FIFO with no consumer.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 1'b0, (i % 2 == 0) ? 32'h1 : 32'h0, 1'b0);
        chk("ovf_set", 64'(overflow), 64'd1);
        drain(0, 8);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // Full FIFO with simultaneous pop and push: nothing dropped.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("clr_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 1'b0, (i % 2 == 0) ? 32'h1 : 32'h0, 1'b0);
        chk("full_no_ovf", 64'(overflow), 64'd0);
        step(1'b0, 1'b1, 1'b0, 32'h1, 1'b1);
        chk("full_push_pop_ovf", 64'(overflow), 64'd0);
        drain(1, 8);

        // Asynchronous reset in the middle of a drain.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("pre_rst_valid", 64'(ev_valid), 64'd1);
        chk("pre_rst_sticky", 64'(sticky_t), 64'd1);
        ev_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_ev_valid", 64'(ev_valid), 64'd0);
        chk("arst_ev_data", 64'(ev_data), 64'd0);
        chk("arst_sticky", 64'(sticky_t), 64'd0);
        chk("arst_tc", 64'(taint_cycles), 64'd0);
        chk("arst_first", 64'(first_cycle), 64'd0);
        chk("arst_state", 64'(state), 64'd0);
        chk("arst_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Data toggle while tainted.
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h2, 1'b1);
        chk("dt_first_valid", 64'(ev_valid), 64'd1);
        chk("dt_first_data", 64'(ev_data), 64'(mk_ev(16'd0, 32'h2, 1'b0)));
        step(1'b0, 1'b1, 1'b1, 32'h2, 1'b1);
`ifdef IFT_MON_DATA_EN
        chk("dt_toggle_valid", 64'(ev_valid), 64'd1);
        chk("dt_toggle_data", 64'(ev_data), 64'(mk_ev(16'd1, 32'h2, 1'b1)));
`else
        chk("dt_toggle_valid", 64'(ev_valid), 64'd0);
`endif
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        chk("dt_end_valid", 64'(ev_valid), 64'd0);
        chk("dt_tc", 64'(taint_cycles), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
